// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multi-cycle RV32 datapath with a single shared
// memory port. It sequences fetch / decode / execute / memory / writeback
// from the IR opcode, stalls on the memory handshake and counts retired
// instructions.
//
// Memory handshake: mem_req_o is held high for the whole access and the
// access completes in the cycle where mem_req_o && mem_ready_i. The request
// is never dropped before ready (except by reset). mem_ready_i is ignored
// in every state that does not request memory.
//
// Optional feature: define CTRL_ITYPE_EN to decode OP-IMM (0010011) through
// an EXEC_I state. Without it, that opcode is handled as illegal.
//
// Control outputs are registered copies of the decode of the next state.
// ir_write_o / pc_write_o are the one exception: they are the FETCH flag
// qualified by mem_ready_i, because the IR must load on the completing cycle.
module multicycle_ctrl_fsm #(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [6:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             adr_src_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             reg_write_o,
    output logic [1:0]       result_src_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [3:0]       dbg_state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef CTRL_ITYPE_EN
    localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
`ifdef CTRL_ITYPE_EN
        ,
        S_EXEC_I   = 4'd11
`endif
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       fetch;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic             retire_d;
    logic [CNT_W-1:0] instret_q;

    // Control word for each state; anything not set stays 0.
    function automatic ctrl_t decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1; c.fetch = 1'b1;
                c.alu_src_b = 2'b10; c.result_src = 2'b10;
            end
            S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
            S_EXEC_R:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
`ifdef CTRL_ITYPE_EN
            S_EXEC_I: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10;
            end
`endif
            S_ALUWB:    begin c.reg_write = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
            S_HALT:     begin c.illegal = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection and retire detection for the current state.
    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXEC_R;
                    OP_BRANCH:         state_d = S_BRANCH;
`ifdef CTRL_ITYPE_EN
                    OP_IMM:            state_d = S_EXEC_I;
`endif
                    default: begin
                        if (ILLEGAL_HALT) begin
                            state_d = S_HALT;
                        end else begin
                            state_d  = S_FETCH;
                            retire_d = 1'b1;
                        end
                    end
                endcase
            end
            // opcode_i is re-checked here; anything but a store takes the load path.
            S_MEMADR:  state_d = (opcode_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready_i) begin
                    state_d  = S_FETCH;
                    retire_d = 1'b1;
                end
            end
            S_EXEC_R: state_d = S_ALUWB;
`ifdef CTRL_ITYPE_EN
            S_EXEC_I: state_d = S_ALUWB;
`endif
            S_ALUWB, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State, registered control word and retire counter; reset wins over retire.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_RST;
            ctrl_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
            if (retire_d) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign mem_req_o    = ctrl_q.mem_req;
    assign mem_we_o     = ctrl_q.mem_we;
    assign adr_src_o    = ctrl_q.adr_src;
    assign ir_write_o   = ctrl_q.fetch & mem_ready_i;
    assign pc_write_o   = ctrl_q.fetch & mem_ready_i;
    assign branch_o     = ctrl_q.branch;
    assign reg_write_o  = ctrl_q.reg_write;
    assign result_src_o = ctrl_q.result_src;
    assign alu_src_a_o  = ctrl_q.alu_src_a;
    assign alu_src_b_o  = ctrl_q.alu_src_b;
    assign alu_op_o     = ctrl_q.alu_op;
    assign illegal_o    = ctrl_q.illegal;
    assign instret_o    = instret_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm. Two instances: dut_a (ILLEGAL_HALT=1,
// CNT_W=32) and dut_b (ILLEGAL_HALT=0, CNT_W=3 so the counter wrap is
// reachable). Inputs are driven 1 time unit after each rising edge; each
// driven cycle pushes the expected outputs of the state the DUT is in during
// that cycle, and a monitor pops and compares on the falling edge.
// The OP-IMM expectations follow the CTRL_ITYPE_EN macro.
module tb_multicycle_ctrl_fsm;

  typedef enum int {
    T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXEC_R, T_EXEC_I, T_ALUWB, T_BRANCH, T_HALT
  } tstate_e;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] ILL = 7'b1111111;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic [6:0] opcode;
  logic       mem_ready;

  logic        req_a, we_a, adr_a, irw_a, pcw_a, br_a, rw_a, ill_a;
  logic [1:0]  res_a, sa_a, sb_a, op_a;
  logic [31:0] cnt_a;
  logic [3:0]  dbg_a;
  logic        req_b, we_b, adr_b, irw_b, pcw_b, br_b, rw_b, ill_b;
  logic [1:0]  res_b, sa_b, sb_b, op_b;
  logic [2:0]  cnt_b;
  logic [3:0]  dbg_b;

  multicycle_ctrl_fsm #(.ILLEGAL_HALT(1'b1), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .mem_req_o(req_a), .mem_we_o(we_a), .adr_src_o(adr_a), .ir_write_o(irw_a),
    .pc_write_o(pcw_a), .branch_o(br_a), .reg_write_o(rw_a), .result_src_o(res_a),
    .alu_src_a_o(sa_a), .alu_src_b_o(sb_a), .alu_op_o(op_a), .illegal_o(ill_a),
    .instret_o(cnt_a), .dbg_state_o(dbg_a)
  );

  multicycle_ctrl_fsm #(.ILLEGAL_HALT(1'b0), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .mem_req_o(req_b), .mem_we_o(we_b), .adr_src_o(adr_b), .ir_write_o(irw_b),
    .pc_write_o(pcw_b), .branch_o(br_b), .reg_write_o(rw_b), .result_src_o(res_b),
    .alu_src_a_o(sa_b), .alu_src_b_o(sb_b), .alu_op_o(op_b), .illegal_o(ill_b),
    .instret_o(cnt_b), .dbg_state_o(dbg_b)
  );

  // {mem_req, mem_we, adr_src, ir_write, pc_write, branch, reg_write,
  //  result_src, alu_src_a, alu_src_b, alu_op, illegal}
  logic [15:0] act_a, act_b;
  assign act_a = {req_a, we_a, adr_a, irw_a, pcw_a, br_a, rw_a, res_a, sa_a, sb_a, op_a, ill_a};
  assign act_b = {req_b, we_b, adr_b, irw_b, pcw_b, br_b, rw_b, res_b, sa_b, sb_b, op_b, ill_b};

  // scoreboard: {dut_sel, outs[15:0], instret[31:0]}
  logic [48:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Expected control outputs for a state, straight from the output table.
  function automatic logic [15:0] exp_outs(tstate_e s, logic rdy);
    logic req, we, adr, irw, pcw, br, rw, ill;
    logic [1:0] res, sa, sb, op;
    {req, we, adr, irw, pcw, br, rw, ill} = '0;
    {res, sa, sb, op} = '0;
    case (s)
      T_FETCH:    begin req = 1; irw = rdy; pcw = rdy; sb = 2'b10; res = 2'b10; end
      T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      T_MEMREAD:  begin req = 1; adr = 1; end
      T_MEMWB:    begin res = 2'b01; rw = 1; end
      T_MEMWRITE: begin req = 1; we = 1; adr = 1; end
      T_EXEC_R:   begin sa = 2'b10; op = 2'b10; end
      T_EXEC_I:   begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      T_ALUWB:    begin rw = 1; end
      T_BRANCH:   begin sa = 2'b10; op = 2'b01; br = 1; end
      T_HALT:     begin ill = 1; end
      default:    ;
    endcase
    return {req, we, adr, irw, pcw, br, rw, res, sa, sb, op, ill};
  endfunction

  // driver: one cycle of inputs plus the expected response for that cycle
  task automatic step(input logic sel, input logic rst_v, input logic [6:0] op,
                      input logic rdy, input tstate_e st, input logic [31:0] cnt);
    @(posedge clk);
    #1;
    if (sel) rst_b_n = rst_v; else rst_a_n = rst_v;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back({sel, exp_outs(st, rdy), cnt});
  endtask

  // monitor: pop and compare every falling edge an entry is pending
  initial begin
    logic [48:0] e;
    logic [15:0] ao;
    logic [31:0] ac;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ao = e[48] ? act_b : act_a;
        ac = e[48] ? {29'd0, cnt_b} : cnt_a;
        checks++;
        if (ao !== e[47:32]) begin
          errors++;
          $display("FAIL outs[%0d] dut_%s: got %h expected %h", n, e[48] ? "b" : "a", ao, e[47:32]);
        end
        checks++;
        if (ac !== e[31:0]) begin
          errors++;
          $display("FAIL instret[%0d] dut_%s: got %0d expected %0d", n, e[48] ? "b" : "a", ac, e[31:0]);
        end
        n++;
      end
    end
  end

  // directed stimulus
  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0;
    @(posedge clk);
    // R-type after a two-cycle reset
    step(0, 0, RR, 1, T_RST, 0);
    step(0, 1, RR, 1, T_RST, 0);
    step(0, 1, RR, 1, T_FETCH, 0);
    step(0, 1, RR, 1, T_DECODE, 0);
    step(0, 1, RR, 1, T_EXEC_R, 0);
    step(0, 1, RR, 1, T_ALUWB, 0);
    // lw with three wait cycles in MEMREAD
    step(0, 1, LW, 1, T_FETCH, 1);
    step(0, 1, LW, 0, T_DECODE, 1);
    step(0, 1, LW, 0, T_MEMADR, 1);
    step(0, 1, LW, 0, T_MEMREAD, 1);
    step(0, 1, LW, 0, T_MEMREAD, 1);
    step(0, 1, LW, 0, T_MEMREAD, 1);
    step(0, 1, LW, 1, T_MEMREAD, 1);
    step(0, 1, LW, 1, T_MEMWB, 1);
    // sw with one wait cycle
    step(0, 1, SW, 1, T_FETCH, 2);
    step(0, 1, SW, 0, T_DECODE, 2);
    step(0, 1, SW, 0, T_MEMADR, 2);
    step(0, 1, SW, 0, T_MEMWRITE, 2);
    step(0, 1, SW, 1, T_MEMWRITE, 2);
    // beq after a stalled fetch
    step(0, 1, BEQ, 0, T_FETCH, 3);
    step(0, 1, BEQ, 1, T_FETCH, 3);
    step(0, 1, BEQ, 1, T_DECODE, 3);
    step(0, 1, BEQ, 1, T_BRANCH, 3);
    // illegal opcode halts; mem_ready toggling must be ignored
    step(0, 1, ILL, 1, T_FETCH, 4);
    step(0, 1, ILL, 1, T_DECODE, 4);
    for (int i = 0; i < 10; i++) step(0, 1, ILL, logic'(i % 2), T_HALT, 4);
    // reset out of HALT, then reset during a MEMREAD stall
    step(0, 0, LW, 1, T_HALT, 4);
    step(0, 1, LW, 1, T_RST, 0);
    step(0, 1, LW, 1, T_FETCH, 0);
    step(0, 1, LW, 0, T_DECODE, 0);
    step(0, 1, LW, 0, T_MEMADR, 0);
    step(0, 1, LW, 0, T_MEMREAD, 0);
    step(0, 0, LW, 0, T_MEMREAD, 0);
    step(0, 1, IMM, 1, T_RST, 0);
    // OP-IMM
    step(0, 1, IMM, 1, T_FETCH, 0);
    step(0, 1, IMM, 1, T_DECODE, 0);
`ifdef CTRL_ITYPE_EN
    step(0, 1, IMM, 1, T_EXEC_I, 0);
    step(0, 1, IMM, 1, T_ALUWB, 0);
    step(0, 0, IMM, 1, T_FETCH, 1);
`else
    step(0, 1, IMM, 1, T_HALT, 0);
    step(0, 0, IMM, 1, T_HALT, 0);
`endif
    // dut_b: illegal retires as NOP; 3-bit counter wraps after 8 retires
    step(1, 0, ILL, 1, T_RST, 0);
    step(1, 1, ILL, 1, T_RST, 0);
    for (int k = 0; k < 9; k++) begin
      step(1, 1, ILL, 1, T_FETCH, 32'(k % 8));
      step(1, 1, ILL, 1, T_DECODE, 32'(k % 8));
    end
    step(1, 1, ILL, 0, T_FETCH, 1);
    step(1, 0, ILL, 0, T_FETCH, 1);
    // drain and report
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
